// File: rtl/srl_fifo_pkg.sv
// Shared helpers for the SRL FIFO family: level width and parameter-range check.
// Latency: none (elaboration-time constants and functions only).
// Backpressure: not applicable.
package srl_fifo_pkg;

  // A FIFO of 2**aw words needs one extra bit to represent the full count.
  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

  // Threshold legality: almost_full in 1..depth, almost_empty in 0..depth-1.
  function automatic bit params_ok(input int aw, input int af_level, input int ae_level);
    int depth;
    depth = 1 << aw;
    return (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/srl_fifo_prog_srl_shift_mem.sv
// Shift-enable storage array with asynchronous read mux, maps onto SRL primitives.
// Latency: write visible one cycle after the shift edge; read is combinational.
// Backpressure: none; the owner decides when to shift.
module srl_shift_mem #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          shift,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  // No reset on storage so the array stays a pure shift register.
  logic [DW-1:0] mem [DEPTH];

  // Shift everything up one slot and load the new word at the bottom.
  always_ff @(posedge clk) begin
    if (shift) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Asynchronous DEPTH:1 read mux; the oldest word sits at index level-1.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/srl_fifo_prog.sv
// FWFT FIFO on SRL storage with programmable almost thresholds and sticky error flags.
// Latency: write to dout 1 cycle on empty; flags/level valid 1 cycle after each edge.
// Backpressure: none; rejected writes/reads are dropped and flagged via overflow/underflow.
module srl_fifo_prog
  import srl_fifo_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = (1 << AW) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [DW-1:0]        din,
  input  logic                 clr_err,
  output logic [DW-1:0]        dout,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [lvl_w(AW)-1:0] level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int LW = lvl_w(AW);
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << AW);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  if (!params_ok(AW, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $fatal(1, "srl_fifo_prog: AF_LEVEL or AE_LEVEL out of range");
  end

  logic          wa;
  logic          ra;
  logic          ovf_evt;
  logic          unf_evt;
  logic [LW-1:0] level_nxt;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  // Flag decode straight from the registered level; no separate pointers.
  always_comb begin
    empty        = (level == '0);
    full         = (level == DEPTH_L);
    almost_full  = (level >= AF_L);
    almost_empty = (level <= AE_L);
  end

  // Acceptance: a simultaneous read frees the slot a full write needs,
  // but an empty read has nothing to pop even if a write arrives.
  always_comb begin
    wa      = wr & (~full | rd);
    ra      = rd & ~empty;
    ovf_evt = wr & ~rd & full;
    unf_evt = rd & empty;
  end

  // Next level; acceptance already prevents wrap at either end.
  always_comb begin
    level_nxt = level;
    case ({wa, ra})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Level register; reset empties the FIFO and ignores same-cycle requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level_nxt;
    end
  end

  // Sticky error flags: a new event beats a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_evt) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Oldest word lives at level-1; at level 0 the address is don't-care (gated below).
  always_comb begin
    raddr = AW'(level - LW'(1));
  end

  srl_shift_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .shift (wa & ~rst),
    .din   (din),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Hide stale storage while empty so reset-undefined contents never leak.
  always_comb begin
    dout = empty ? '0 : rdata;
  end

endmodule

// File: tb/tb_srl_fifo_prog.sv
module tb_srl_fifo_prog;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 14;
  localparam int AEL = 2;

  logic          clk;
  logic          rst;
  logic          wr;
  logic          rd;
  logic [DW-1:0] din;
  logic          clr_err;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  int checks;
  int failures;

  srl_fifo_prog #(
    .DW       (DW),
    .AW       (AW),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .clr_err      (clr_err),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] din;
    int          exp_level;
    logic [15:0] exp_dout;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic w, input logic d, input logic c,
                              input logic [15:0] di, input int lv, input logic [15:0] dq,
                              input logic ov, input logic un);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = d; v.clr = c; v.din = di;
    v.exp_level = lv; v.exp_dout = dq; v.exp_ovf = ov; v.exp_unf = un;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  // Compare every output against the expected level/dout/sticky values;
  // threshold flags come from the bench's own decode of the expected level.
  task automatic check_all(input int idx, input int lv, input logic [15:0] dq,
                           input logic ov, input logic un);
    chk("level", idx, 32'(level), 32'(lv));
    chk("dout", idx, 32'(dout), 32'(dq));
    chk("empty", idx, 32'(empty), 32'(lv == 0));
    chk("full", idx, 32'(full), 32'(lv == DEPTH));
    chk("almost_full", idx, 32'(almost_full), 32'(lv >= AFL));
    chk("almost_empty", idx, 32'(almost_empty), 32'(lv <= AEL));
    chk("overflow", idx, 32'(overflow), 32'(ov));
    chk("underflow", idx, 32'(underflow), 32'(un));
  endtask

  task automatic step(input logic r, input logic w, input logic d, input logic c, input logic [15:0] di);
    rst = r; wr = w; rd = d; clr_err = c; din = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;

    // Reset and idle
    add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
    // Fill 0x0001..0x0010; oldest word stays on dout
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 0, 16'(i), i, 16'h0001, 0, 0);
    // Write into full FIFO: dropped, overflow set
    add(0, 1, 0, 0, 16'hBEEF, 16, 16'h0001, 1, 0);
    add(0, 0, 0, 1, 16'h0000, 16, 16'h0001, 0, 0);
    // Drain: after read j, next word j+1 shows (0 once empty)
    for (int j = 1; j <= 16; j++)
      add(0, 0, 1, 0, 16'h0000, 16 - j, (j == 16) ? 16'h0000 : 16'(j + 1), 0, 0);
    // wr & rd on empty: write lands, read rejected
    add(0, 1, 1, 0, 16'h1234, 1, 16'h1234, 0, 1);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 1);
    // clr_err with an empty read: set wins
    add(0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 1);
    add(0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].rst, vq[k].wr, vq[k].rd, vq[k].clr, vq[k].din);
      check_all(k, vq[k].exp_level, vq[k].exp_dout, vq[k].exp_ovf, vq[k].exp_unf);
    end

    // Steady streaming at level 5
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 16'(16'h0100 + k));
      check_all(100 + k, k + 1, 16'h0100, 0, 0);
    end
    for (int c = 0; c < 20; c++) begin
      step(0, 1, 1, 0, 16'(16'h0105 + c));
      check_all(200 + c, 5, 16'(16'h0101 + c), 0, 0);
    end

    // Raise to level 8, then reset while writing
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 16'(16'h0200 + k));
      check_all(300 + k, 6 + k, 16'h0114, 0, 0);
    end
    step(1, 1, 0, 0, 16'h5555);
    check_all(400, 0, 16'h0000, 0, 0);
    step(0, 1, 0, 0, 16'h00AA);
    check_all(401, 1, 16'h00AA, 0, 0);
    step(0, 0, 0, 0, 16'h0000);
    check_all(402, 1, 16'h00AA, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srl_fifo_prog.md
# srl_fifo_prog

Parametrised first-word-fall-through FIFO built on a shift-register (SRL) storage array. It adds programmable almost-full/almost-empty thresholds, a fill-level output and sticky overflow/underflow error flags. It sits between the MIDI/synth sample producers and the I2S transmit path, and replaces the fixed 16x16 SRL FIFO wherever width, depth or flow-control margin must differ.

## Interface
- DW, 16, data width in bits
- AW, 4, address width; DEPTH = 2**AW words
- AF_LEVEL, DEPTH-2, almost_full asserted when level >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL; legal range 0..DEPTH-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  1  write request; din captured when accepted
- rd  in  1  read request; pops the word currently on dout when accepted
- din  in  DW  write data
- clr_err  in  1  clears overflow/underflow sticky flags
- dout  out  DW  oldest stored word (FWFT); forced to 0 when empty
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  AW+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage is an array of DEPTH words of DW bits, with no reset. On every accepted write, entries shift up by one (mem[i] <= mem[i-1]) and mem[0] <= din.
- Read address is level-1. dout = mem[level-1] when level > 0, else 0.
- Acceptance rules (wa = write accepted, ra = read accepted):
  - wr & ~rd: wa = ~full; if full, the write is dropped and overflow is set.
  - ~wr & rd: ra = ~empty; if empty, the read is dropped and underflow is set.
  - wr & rd, 0 < level < DEPTH: both are accepted; level is unchanged; the shift keeps dout pointing at the next-oldest word.
  - wr & rd, full: both are accepted; level stays DEPTH; no overflow.
  - wr & rd, empty: the write is accepted and the read is rejected; level becomes 1; underflow is set.
- Level update: level + wa - ra. It never wraps: no increment at DEPTH, no decrement at 0.
- All flags are decoded combinationally from the registered level. There is no separate address counter.
- Sticky flags: an error event sets the flag; clr_err clears it; if both occur in the same cycle, set wins. Only rst and clr_err clear the flags.
- Reset values: level = 0, empty = 1, full = 0, almost_full = 0, almost_empty = 1, overflow = 0, underflow = 0, dout = 0. Storage contents are undefined but are never visible, because dout is gated while empty.
- Parameter legality is checked at elaboration; an illegal AF_LEVEL or AE_LEVEL is a fatal error.

## Timing
- Write-to-dout latency on an empty FIFO is 1 cycle: wr high at edge k, dout valid and empty low after edge k.
- Read: rd high at edge k means the word on dout before edge k was consumed; dout shows the next word after edge k.
- The flags and level reflect every accepted operation one cycle after the edge, with no extra pipeline.
- rd and wr are sampled every cycle. There is no ready/valid handshake; callers gate rd with ~empty and wr with ~full.
- Reset mid-operation: at the rst edge the FIFO becomes empty and the flags take their reset values. wr/rd in the reset cycle are ignored and set no errors.
- Critical path: level register -> DEPTH:1 read mux -> dout gating. Combinational dout is required so the storage maps onto SRL primitives.

## Structure
- Shared package srl_fifo_pkg holds the level-width helper (AW+1) and the parameter-range check function. It is reused by future FIFO variants.
- One sub-module, srl_shift_mem (params DW, AW), contains the shift-enable storage array and the asynchronous read mux.
- The top level holds the accept logic, level counter, flag decode and sticky error registers.

## Test plan
All scenarios use DW = 16, AW = 4, AF_LEVEL = 14, AE_LEVEL = 2.
- Reset, then idle -> level = 0, empty = 1, almost_empty = 1, full = 0, dout = 0x0000, overflow = 0, underflow = 0.
- Write 0x0001..0x0010 (16 words), then read 16 -> full = 1 after the 16th write; almost_full from level 14; dout sequence 0x0001..0x0010 in order; empty = 1 at the end.
- Full FIFO, wr with din = 0xBEEF and no rd -> level stays 16, overflow = 1, contents intact (read-back 0x0001..0x0010); clr_err -> overflow = 0.
- Empty FIFO, wr & rd with din = 0x1234 -> level = 1, dout = 0x1234, underflow = 1. Then clr_err together with a read while empty -> underflow remains 1 (set wins).
- Level 5, with 20 cycles of simultaneous wr & rd -> level stays 5, dout follows the input stream delayed by 5 words, no error flags.
- Level 8, assert rst while wr = 1 -> level = 0 and all outputs at reset values next cycle; a subsequent write of 0x00AA -> dout = 0x00AA.
